// File: rtl/addac_unit_if.sv
// ---------------------------------------------------------------------------
// addac_unit_if
//
// Purpose:
//   Groups the operand, select and result signals of the ADDAC accumulator
//   leaf into one bundle.
//
// Signals:
//   a     operand (WIDTH bits)
//   sel0  operation select, LSB
//   sel1  operation select, MSB
//   s     operation result (WIDTH bits, combinational)
//   cout  carry / borrow / clamp flag (combinational)
//
// Modports:
//   master  drives a/sel0/sel1 and observes s/cout
//   slave   the accumulator unit itself
// ---------------------------------------------------------------------------
interface addac_unit_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic             sel0;
    logic             sel1;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (
        output a,
        output sel0,
        output sel1,
        input  s,
        input  cout
    );

    modport slave (
        input  a,
        input  sel0,
        input  sel1,
        output s,
        output cout
    );
endinterface

// File: rtl/addac_unit.sv
// ---------------------------------------------------------------------------
// addac_unit
//
// Purpose:
//   Small add/accumulate datapath. Each cycle {sel1,sel0} selects LOAD, ADD,
//   SUB or HOLD between the operand a and the internal accumulator acc.
//   The result is presented combinationally on s/cout and captured into acc
//   on the next rising clock edge.
//
// Ports:
//   clk   system clock, rising edge active
//   rst   asynchronous active-low reset; clears acc and forces s/cout to 0
//   bus   addac_unit_if.slave (a, sel0, sel1 in; s, cout out)
//
// Configuration:
//   ADDAC_SATURATE_EN  when defined, ADD clamps to all-ones on carry and SUB
//                      clamps to zero on borrow; cout then flags the clamp.
//                      When undefined, results wrap modulo 2^WIDTH.
// ---------------------------------------------------------------------------
module addac_unit #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    addac_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_HOLD = 2'b11
    } op_e;

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum_wide;
    logic [WIDTH:0]   diff_wide;
    logic [WIDTH-1:0] result;
    logic             flag;
    op_e              op;

    assign op = op_e'({bus.sel1, bus.sel0});

    // Both arithmetic paths are evaluated one bit wider than the data. The
    // extra MSB of the sum is the carry; the extra MSB of the difference is
    // set exactly when a > acc, i.e. it is the borrow.
    always_comb begin
        sum_wide  = {1'b0, acc} + {1'b0, bus.a};
        diff_wide = {1'b0, acc} - {1'b0, bus.a};
    end

    // Result and flag selection. Reset is treated as a combinational override
    // so s/cout read zero for as long as rst is low, not just after an edge.
    always_comb begin
        result = '0;
        flag   = 1'b0;
        if (rst) begin
            case (op)
                OP_LOAD: begin
                    result = bus.a;
                    flag   = 1'b0;
                end
                OP_ADD: begin
                    flag = sum_wide[WIDTH];
`ifdef ADDAC_SATURATE_EN
                    result = sum_wide[WIDTH] ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];
`else
                    result = sum_wide[WIDTH-1:0];
`endif
                end
                OP_SUB: begin
                    flag = diff_wide[WIDTH];
`ifdef ADDAC_SATURATE_EN
                    result = diff_wide[WIDTH] ? {WIDTH{1'b0}} : diff_wide[WIDTH-1:0];
`else
                    result = diff_wide[WIDTH-1:0];
`endif
                end
                OP_HOLD: begin
                    result = acc;
                    flag   = 1'b0;
                end
                default: begin
                    result = '0;
                    flag   = 1'b0;
                end
            endcase
        end
    end

    assign bus.s    = result;
    assign bus.cout = flag;

    // The accumulator captures whatever is on s, so the result of one cycle
    // becomes the acc operand of the next. cout is intentionally not stored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else begin
            acc <= result;
        end
    end

endmodule

// File: tb/tb_addac_unit.sv
// ---------------------------------------------------------------------------
// tb_addac_unit
//
// Purpose:
//   Self-checking bench for addac_unit. A driver issues one operation per
//   clock (directed sequence, then random traffic) and pushes the expected
//   s/cout, produced by an integer reference model, into a queue. A monitor
//   pops and compares on every falling edge, when the combinational outputs
//   of the current cycle are stable.
//
// Configuration:
//   ADDAC_SATURATE_EN  selects the clamping reference model to match the DUT.
// ---------------------------------------------------------------------------
module tb_addac_unit;

    localparam int WIDTH   = 4;
    localparam int MAX_VAL = (1 << WIDTH) - 1;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             cout;
        string            tag;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   model_acc;
    exp_t exp_q[$];

    addac_unit_if #(.WIDTH(WIDTH)) bus ();

    addac_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operation rules.
    function automatic exp_t model_op(input int acc_v, input int a_v, input int op,
                                      input bit rst_n, input string tag);
        exp_t e;
        int   raw;
        int   res;
        bit   c;
        res = 0;
        c   = 1'b0;
        if (rst_n) begin
            case (op)
                0: res = a_v;
                1: begin
                    raw = acc_v + a_v;
                    c   = (raw > MAX_VAL);
`ifdef ADDAC_SATURATE_EN
                    res = c ? MAX_VAL : raw;
`else
                    res = raw % (MAX_VAL + 1);
`endif
                end
                2: begin
                    c = (a_v > acc_v);
`ifdef ADDAC_SATURATE_EN
                    res = c ? 0 : acc_v - a_v;
`else
                    res = (acc_v - a_v + MAX_VAL + 1) % (MAX_VAL + 1);
`endif
                end
                default: res = acc_v;
            endcase
        end
        e.s    = res[WIDTH-1:0];
        e.cout = c;
        e.tag  = tag;
        return e;
    endfunction

    task automatic check_output(input string tag, input logic [WIDTH-1:0] exp_s,
                                input logic exp_c);
        checks++;
        if (bus.s !== exp_s || bus.cout !== exp_c) begin
            failures++;
            $display("[TB] FAIL %s: got s=%0d cout=%0b, expected s=%0d cout=%0b",
                     tag, bus.s, bus.cout, exp_s, exp_c);
        end
    endtask

    // Drives one operation just after the rising edge and queues its result.
    task automatic apply_stimulus(input bit rst_n, input int a_v, input int op,
                                  input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = rst_n;
        bus.a    = a_v[WIDTH-1:0];
        bus.sel1 = op[1];
        bus.sel0 = op[0];
        if (!rst_n) model_acc = 0;
        e = model_op(model_acc, a_v, op, rst_n, tag);
        exp_q.push_back(e);
        model_acc = rst_n ? int'(e.s) : 0;
    endtask

    // Pulses reset low between clock edges, checks the immediate clear, then
    // issues an operation that must see acc = 0.
    task automatic async_reset_pulse(input int a_v, input int op, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("async_reset_clear", '0, 1'b0);
        #1;
        rst       = 1'b1;
        model_acc = 0;
        bus.a     = a_v[WIDTH-1:0];
        bus.sel1  = op[1];
        bus.sel0  = op[0];
        e = model_op(model_acc, a_v, op, 1'b1, tag);
        exp_q.push_back(e);
        model_acc = int'(e.s);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output(e.tag, e.s, e.cout);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        model_acc = 0;
        rst       = 1'b0;
        bus.a     = 4'b1010;
        bus.sel0  = 1'b1;
        bus.sel1  = 1'b0;

        apply_stimulus(1'b0, 4'b1010, 1, "reset_held");
        apply_stimulus(1'b1, 0, 3, "reset_release_hold");

        apply_stimulus(1'b1, 4'b0101, 0, "load_0101");
        apply_stimulus(1'b1, 4'b1111, 3, "hold_after_load");

        apply_stimulus(1'b1, 4'b0011, 0, "load_0011");
        apply_stimulus(1'b1, 4'b0100, 1, "add_0100");
        apply_stimulus(1'b1, 4'b0010, 1, "add_0010");

        apply_stimulus(1'b1, 4'b1111, 0, "load_1111");
        apply_stimulus(1'b1, 4'b0001, 1, "add_carry_wrap");
        apply_stimulus(1'b1, 4'b0000, 3, "hold_after_carry");

        apply_stimulus(1'b1, 4'b1000, 0, "load_1000");
        apply_stimulus(1'b1, 4'b0011, 2, "sub_0011");
        apply_stimulus(1'b1, 4'b0110, 2, "sub_borrow");

        apply_stimulus(1'b1, 4'b1001, 0, "load_1001");
        apply_stimulus(1'b1, 4'b0000, 1, "add_zero");
        apply_stimulus(1'b1, 4'b0000, 2, "sub_zero");
        apply_stimulus(1'b1, 4'b0000, 0, "load_0000");
        apply_stimulus(1'b1, 4'b0001, 2, "sub_0_minus_1");

        apply_stimulus(1'b1, 4'b0100, 0, "load_0100");
        apply_stimulus(1'b1, 4'b0010, 1, "add_to_0110");
        async_reset_pulse(4'b0010, 1, "add_after_async_reset");

        for (int i = 0; i < 300; i++) begin
            bit rst_n;
            rst_n = ($urandom_range(0, 19) != 0);
            apply_stimulus(rst_n, int'($urandom_range(0, MAX_VAL)),
                           int'($urandom_range(0, 3)), "random_op");
        end

        apply_stimulus(1'b1, 0, 3, "final_hold");
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
